// File: rtl/lcd_text_driver_if.sv
// Application-side bus of lcd_text_driver: screen writes, refresh request,
// status flags and the HD44780 pins.
interface lcd_text_driver_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       init_done;
    logic       done;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, init_done, done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, init_done, done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780-style 2x16 LCD driver: 32-byte screen buffer, power-up wait, init and paced refresh.
// Optional macro LCD_AUTO_REFRESH_EN: refresh continuously after init, start ignored.
module lcd_text_driver #(
    parameter int unsigned POWERUP_CYC = 5,
    parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
    input logic              clk_100hz,
    input logic              rst,
    lcd_text_driver_if.slave bus
);
    localparam int unsigned      SCR_DEPTH = 32;
    localparam int unsigned      IDX_W     = 6;
    localparam int unsigned      PWR_W     = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;
    localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(POWERUP_CYC - 1);
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(3);
    localparam logic [IDX_W-1:0] LINE2_IDX = IDX_W'(17);
    localparam logic [IDX_W-1:0] TX_LAST   = IDX_W'(33);
`ifdef LCD_AUTO_REFRESH_EN
    localparam bit AUTO_REFRESH = 1'b1;
`else
    localparam bit AUTO_REFRESH = 1'b0;
`endif

    typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, REFRESH} state_e;

    state_e           state_q;
    logic             strobe_q;
    logic [PWR_W-1:0] pwr_cnt_q;
    logic [IDX_W-1:0] tx_idx_q;
    logic             pending_q;
    logic             busy_q;
    logic             init_done_q;
    logic             done_q;
    logic             lcd_e_q;
    logic             lcd_rs_q;
    logic [7:0]       lcd_data_q;
    logic [7:0]       scr_q [SCR_DEPTH];

    logic [7:0]       wr_byte_c;
    logic [IDX_W-1:0] nxt_idx_c;
    logic             nxt_rs_c;
    logic [7:0]       nxt_byte_c;
    logic [7:0]       nxt_cmd_c;

    // Sanitised write data and the byte for the following transaction
    always_comb begin
        wr_byte_c  = (bus.wr_data < 8'h20 || bus.wr_data > 8'h7E) ? FILL_CHAR : bus.wr_data;
        nxt_idx_c  = tx_idx_q + IDX_W'(1);
        nxt_rs_c   = (nxt_idx_c != LINE2_IDX);
        nxt_byte_c = 8'hC0;
        if (nxt_idx_c < LINE2_IDX) begin
            nxt_byte_c = scr_q[5'(nxt_idx_c - IDX_W'(1))];
        end else if (nxt_idx_c > LINE2_IDX) begin
            nxt_byte_c = scr_q[5'(nxt_idx_c - IDX_W'(2))];
        end
        case (nxt_idx_c[1:0])
            2'd1:    nxt_cmd_c = 8'h0C;
            2'd2:    nxt_cmd_c = 8'h06;
            2'd3:    nxt_cmd_c = 8'h01;
            default: nxt_cmd_c = 8'h38;
        endcase
    end

    // Sequencer: each transaction is a SETUP cycle (e low) then a STROBE cycle (e high)
    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            strobe_q    <= 1'b0;
            pwr_cnt_q   <= '0;
            tx_idx_q    <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            for (int i = 0; i < SCR_DEPTH; i++) begin
                scr_q[i] <= FILL_CHAR;
            end
        end else begin
            done_q <= 1'b0;
            if (bus.wr_en) begin
                scr_q[bus.wr_addr] <= wr_byte_c;
            end
            case (state_q)
                PWR_WAIT: begin
                    if (bus.start) pending_q <= 1'b1;
                    if (pwr_cnt_q == PWR_LAST) begin
                        state_q    <= INIT;
                        tx_idx_q   <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= 8'h38;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + PWR_W'(1);
                    end
                end
                INIT: begin
                    if (bus.start) pending_q <= 1'b1;
                    if (!strobe_q) begin
                        strobe_q <= 1'b1;
                        lcd_e_q  <= 1'b1;
                    end else begin
                        strobe_q <= 1'b0;
                        lcd_e_q  <= 1'b0;
                        if (tx_idx_q == INIT_LAST) begin
                            init_done_q <= 1'b1;
                            pending_q   <= 1'b0;
                            if (AUTO_REFRESH || pending_q || bus.start) begin
                                state_q    <= REFRESH;
                                tx_idx_q   <= '0;
                                lcd_rs_q   <= 1'b0;
                                lcd_data_q <= 8'h80;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tx_idx_q   <= nxt_idx_c;
                            lcd_data_q <= nxt_cmd_c;
                        end
                    end
                end
                IDLE: begin
                    if (bus.start && !AUTO_REFRESH) begin
                        state_q    <= REFRESH;
                        busy_q     <= 1'b1;
                        tx_idx_q   <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= 8'h80;
                    end
                end
                REFRESH: begin
                    if (!strobe_q) begin
                        strobe_q <= 1'b1;
                        lcd_e_q  <= 1'b1;
                    end else begin
                        strobe_q <= 1'b0;
                        lcd_e_q  <= 1'b0;
                        if (tx_idx_q == TX_LAST) begin
                            done_q <= 1'b1;
                            if (AUTO_REFRESH) begin
                                tx_idx_q   <= '0;
                                lcd_rs_q   <= 1'b0;
                                lcd_data_q <= 8'h80;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            // Buffer byte is captured here, as its SETUP cycle begins
                            tx_idx_q   <= nxt_idx_c;
                            lcd_rs_q   <= nxt_rs_c;
                            lcd_data_q <= nxt_byte_c;
                        end
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;
    assign bus.done      = done_q;
    assign bus.lcd_e     = lcd_e_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_data  = lcd_data_q;
endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed self-checking bench for lcd_text_driver (default build, auto refresh off).
module tb_lcd_text_driver;
    logic clk_100hz = 1'b0;
    logic rst = 1'b0;

    lcd_text_driver_if bus();

    lcd_text_driver u_dut (
        .clk_100hz(clk_100hz),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_100hz = ~clk_100hz;

    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         hold_err = 0;
    logic       e_prev = 1'b0;
    logic [8:0] prev_bus = 9'h000;
    logic [8:0] cap_q [$];
    logic [7:0] model [32];
    logic [8:0] exp_s [34];
    logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    // Capture {rs,data} at each rising lcd_e; rs/data must be unchanged from SETUP
    always @(negedge clk_100hz) begin
        if (bus.lcd_e && !e_prev) begin
            cap_q.push_back({bus.lcd_rs, bus.lcd_data});
            if ({bus.lcd_rs, bus.lcd_data} !== prev_bus) hold_err++;
        end
        if (bus.done) done_cnt++;
        e_prev   = bus.lcd_e;
        prev_bus = {bus.lcd_rs, bus.lcd_data};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_100hz);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
        model[a]    = (d < 8'h20 || d > 8'h7E) ? 8'h20 : d;
    endtask

    task automatic wr_str(input logic [4:0] a, input string s);
        for (int i = 0; i < s.len(); i++) wr(5'(a + i), s[i]);
    endtask

    task automatic build_exp();
        exp_s[0]  = 9'h080;
        exp_s[17] = 9'h0C0;
        for (int i = 0; i < 16; i++) begin
            exp_s[1 + i]  = {1'b1, model[i]};
            exp_s[18 + i] = {1'b1, model[16 + i]};
        end
    endtask

    task automatic chk_stream(input string tag, input int base);
        chk({tag, "_len"}, cap_q.size(), base + 34);
        for (int i = 0; i < 34; i++) begin
            if (base + i < cap_q.size())
                chk($sformatf("%s_tx%0d", tag, i), cap_q[base + i], exp_s[i]);
        end
    endtask

    // Start in cycle 0; optional write / extra start in cycle wr_cyc / st2_cyc
    task automatic do_refresh(input int wr_cyc, input logic [4:0] wa, input logic [7:0] wd,
                              input int st2_cyc, output int lat);
        bus.start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 150 && lat < 0; k++) begin
            step();
            bus.start   = (k == st2_cyc);
            bus.wr_en   = (k == wr_cyc);
            bus.wr_addr = wa;
            bus.wr_data = wd;
            if (bus.done) lat = k;
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;

        // T1: async reset values, power-up wait, init commands
        #1 rst = 1'b1;
        #2;
        chk("rst_e", bus.lcd_e, 0);
        chk("rst_rs", bus.lcd_rs, 0);
        chk("rst_rw", bus.lcd_rw, 0);
        chk("rst_data", bus.lcd_data, 8'h00);
        chk("rst_busy", bus.busy, 1);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_done", bus.done, 0);
        step(); step();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("pwr_e_c%0d", i), bus.lcd_e, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("init_e_%0d", i), bus.lcd_e, 1);
            chk($sformatf("init_cmd_%0d", i), {bus.lcd_rs, bus.lcd_data}, {1'b0, cmds[i]});
            chk($sformatf("init_done_early_%0d", i), bus.init_done, 0);
            step();
            chk($sformatf("init_e_low_%0d", i), bus.lcd_e, 0);
        end
        chk("init_done_rise", bus.init_done, 1);
        chk("init_busy_fall", bus.busy, 0);

        // T2: "mode 0" / "watch" refresh and start-to-done latency
        wr_str(5'd0, "mode 0");
        wr_str(5'd16, "watch");
        build_exp();
        step();
        cap_q.delete();
        done_cnt = 0;
        bus.start = 1'b1;
        step();
        chk("t2_first_setup", {bus.lcd_e, bus.lcd_rs, bus.lcd_data}, {2'b00, 8'h80});
        chk("t2_busy", bus.busy, 1);
        do_refresh(-1, 5'd0, 8'h00, 1, lat);
        chk("t2_latency", lat + 1, 69);
        step();
        chk("t2_busy_after", bus.busy, 0);
        chk("t2_done_count", done_cnt, 1);
        chk_stream("t2", 0);
        if (cap_q.size() >= 34) begin
            chk("t2_m", cap_q[1], 9'h16D);
            chk("t2_0", cap_q[6], 9'h130);
            chk("t2_fill", cap_q[7], 9'h120);
            chk("t2_line2_cmd", cap_q[17], 9'h0C0);
            chk("t2_w", cap_q[18], 9'h177);
        end

        // T3: non-printable writes stored as fill
        wr(5'd3, 8'h07);
        wr(5'd4, 8'h7F);
        build_exp();
        step();
        cap_q.delete();
        do_refresh(-1, 5'd0, 8'h00, -1, lat);
        step();
        chk_stream("t3", 0);
        if (cap_q.size() >= 34) begin
            chk("t3_ctrl_char", cap_q[4], 9'h120);
            chk("t3_del_char", cap_q[5], 9'h120);
        end

        // T5: write addr 10 during its SETUP cycle (cycle 23): old then new
        build_exp();
        cap_q.delete();
        do_refresh(23, 5'd10, 8'h58, -1, lat);
        model[10] = 8'h58;
        step();
        chk_stream("t5a", 0);
        if (cap_q.size() >= 34) chk("t5_old_sent", cap_q[11], 9'h120);
        build_exp();
        cap_q.delete();
        do_refresh(-1, 5'd0, 8'h00, -1, lat);
        step();
        chk_stream("t5b", 0);
        if (cap_q.size() >= 34) chk("t5_new_sent", cap_q[11], 9'h158);

        // T6: reset at refresh transaction 12, then start during INIT
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 2; k <= 25; k++) step();
        chk("t6_tx12_setup", {bus.lcd_e, bus.lcd_rs, bus.lcd_data}, {2'b01, model[11]});
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_e", bus.lcd_e, 0);
        chk("t6_rst_rs", bus.lcd_rs, 0);
        chk("t6_rst_data", bus.lcd_data, 8'h00);
        chk("t6_rst_busy", bus.busy, 1);
        chk("t6_rst_init_done", bus.init_done, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        cap_q.delete();
        done_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("t6_pwr_e_c%0d", i), bus.lcd_e, 0);
        end
        step(); step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 40 && !bus.init_done; k++) step();
        chk("t6_init_done", bus.init_done, 1);
        chk("t6_auto_refresh_setup", {bus.lcd_e, bus.lcd_rs, bus.lcd_data}, {2'b00, 8'h80});
        chk("t6_busy", bus.busy, 1);
        for (int k = 1; k <= 150 && !bus.done; k++) begin
            bus.start = (k == 10);
            step();
        end
        bus.start = 1'b0;
        chk("t6_done_seen", bus.done, 1);
        for (int k = 0; k < 80; k++) step();
        chk("t6_single_done", done_cnt, 1);
        chk("t6_idle_busy", bus.busy, 0);
        build_exp();
        for (int i = 0; i < 4; i++) begin
            if (i < cap_q.size()) chk($sformatf("t6_init_cmd_%0d", i), cap_q[i], {1'b0, cmds[i]});
        end
        chk_stream("t6", 4);

        chk("rs_data_hold", hold_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
